// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - shared widths, FSM encoding and range helper for data_ram
package data_ram_pkg;

   localparam int DATA_ADDR_W = 32;
   localparam int DATA_W      = 32;
   localparam int BYTE_SEL_W  = 4;

   typedef logic [DATA_ADDR_W-1:0] data_addr_bus_t;
   typedef logic [DATA_W-1:0]      data_bus_t;
   typedef logic [BYTE_SEL_W-1:0]  byte_sel_bus_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   typedef struct packed {
      logic           we;
      data_addr_bus_t addr;
      byte_sel_bus_t  sel;
      data_bus_t      data;
   } req_t;

   // A byte address is in range when every bit above the word index is zero.
   function automatic logic addr_in_range(input data_addr_bus_t addr, input int depth_log2);
      return (addr >> (depth_log2 + 2)) == '0;
   endfunction

endpackage

// File: rtl/data_ram_array.sv
// rtl/data_ram_array.sv - word storage with one sync read port and one byte-enabled sync write port
module data_ram_array
   import data_ram_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_idx,
   output data_bus_t             rd_data,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_idx,
   input  byte_sel_bus_t         wr_sel,
   input  data_bus_t             wr_data
);

   data_bus_t mem [1 << DEPTH_LOG2];

   // Registered read; the word is presented on the edge that enters ACK.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
   end

   // Byte-lane write; lane b carries data bits [8b+7:8b].
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BYTE_SEL_W; b++) begin
            if (wr_sel[b]) begin
               mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/data_ram.sv
// rtl/data_ram.sv - wait-state data memory with request latch, range check and one-cycle acknowledge
module data_ram
   import data_ram_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ce_i,
   input  logic                       we_i,
   input  logic [DATA_ADDR_W-1:0]     addr_i,
   input  logic [BYTE_SEL_W-1:0]      sel_i,
   input  logic [DATA_W-1:0]          data_i,
   output logic [DATA_W-1:0]          data_o,
   output logic                       ack_o,
   output logic                       err_o
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t     state;
   logic [3:0] cnt;
   req_t       req_q;
   logic       load_q;

   req_t       cur_req;
   logic       cur_in_range;
   logic       go_ack;
   data_bus_t  rd_data;
   logic       unused_addr_lsb;

   // In IDLE the live inputs are the request; afterwards only the latched copy is used.
   always_comb begin
      cur_req = req_q;
      if (state == ST_IDLE) begin
         cur_req = '{we: we_i, addr: addr_i, sel: sel_i, data: data_i};
      end
   end

   assign cur_in_range    = addr_in_range(cur_req.addr, DEPTH_LOG2);
   assign unused_addr_lsb = ^cur_req.addr[1:0];

   // The edge that enters ACK; held off while reset is asserted so nothing commits.
   assign go_ack = rst && (((state == ST_IDLE) && ce_i && (WAIT_INIT == 4'd0)) ||
                           ((state == ST_WAIT) && (cnt <= 4'd1)));

   data_ram_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk     (clk),
      .rd_en   (go_ack && !cur_req.we && cur_in_range),
      .rd_idx  (cur_req.addr[DEPTH_LOG2+1:2]),
      .rd_data (rd_data),
      .wr_en   (go_ack && cur_req.we && cur_in_range),
      .wr_idx  (cur_req.addr[DEPTH_LOG2+1:2]),
      .wr_sel  (cur_req.sel),
      .wr_data (cur_req.data)
   );

   // Request FSM: accept in IDLE, count wait states, pulse ack for one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         cnt    <= 4'd0;
         req_q  <= '0;
         ack_o  <= 1'b0;
         err_o  <= 1'b0;
         load_q <= 1'b0;
      end else begin
         ack_o  <= 1'b0;
         err_o  <= 1'b0;
         load_q <= 1'b0;
         if (go_ack) begin
            ack_o  <= 1'b1;
            err_o  <= !cur_in_range;
            load_q <= !cur_req.we && cur_in_range;
         end
         unique case (state)
            ST_IDLE: begin
               if (ce_i) begin
                  req_q <= cur_req;
                  cnt   <= WAIT_INIT;
                  state <= (WAIT_INIT == 4'd0) ? ST_ACK : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt <= 4'd1) begin
                  cnt   <= 4'd0;
                  state <= ST_ACK;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_ACK: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Load data is visible only during the ACK of an in-range load.
   assign data_o = load_q ? rd_data : '0;

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of storage size in 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning wait states inserted before each acknowledge.
REQ-003 SHALL have port: clk  input  1  sole clock, all state changes on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: ce_i  input  1  request valid from the memory-access stage.
REQ-006 SHALL have port: we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: addr_i  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port: sel_i  input  4  byte enables, big-endian; sel_i[3] selects data bits 31:24, which sit at byte offset 0.
REQ-009 SHALL have port: data_i  input  32  store data.
REQ-010 SHALL have port: data_o  output  32  load data, valid while ack_o = 1.
REQ-011 SHALL have port: ack_o  output  1  one-cycle transaction completion pulse.
REQ-012 SHALL have port: err_o  output  1  out-of-range flag, valid only while ack_o = 1.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and ACK.
REQ-014 SHALL, in IDLE with ce_i = 1 at a rising edge, latch we_i, addr_i, sel_i and data_i, load the wait counter with WAIT_CYCLES, and move to WAIT, or to ACK when WAIT_CYCLES = 0.
REQ-015 SHALL, in WAIT, decrement the counter each cycle and move to ACK on the edge where the counter reaches 0.
REQ-016 SHALL keep ack_o = 1 for exactly one cycle in ACK, then return to IDLE.
REQ-017 SHALL sample ce_i only in IDLE; when ce_i = 1 in the cycle after ACK, a new transaction starts, so back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
REQ-018 SHALL assert ack_o exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-019 SHALL use only the latched request copies after acceptance; ce_i falling mid-transaction does not abort it.
REQ-020 SHALL take the word index from addr[DEPTH_LOG2+1:2].
REQ-021 SHALL treat a request as out-of-range when any of addr[31:DEPTH_LOG2+2] is nonzero; it then acknowledges with err_o = 1, data_o = 0 and leaves storage unmodified.
REQ-022 SHALL, for a store, commit only the enabled bytes on the edge entering ACK; sel_i = 0 writes nothing but still acknowledges.
REQ-023 SHALL, for a load, drive data_o with the full 32-bit word during ACK, ignoring sel; byte extraction and sign extension remain the memory-access stage's job.
REQ-024 SHALL return, for a load issued immediately after a store to the same word, the newly stored data.
REQ-025 SHALL hold data_o = 0, ack_o = 0 and err_o = 0 in every cycle outside ACK.

Reset
REQ-026 SHALL, while rst = 0, immediately force state to IDLE, the counter to 0, data_o to 0x00000000, ack_o to 0, err_o to 0, and clear the latched request.
REQ-027 SHALL drop an in-flight transaction when reset asserts mid-operation: no acknowledge is produced, and a store not yet committed is not written.
REQ-028 SHALL NOT reset storage contents.
REQ-029 SHALL accept its first request at the first rising edge after rst deasserts.

Structure
REQ-030 SHALL take the width constants DataAddrBus (31:0), DataBus (31:0) and ByteSelBus (3:0), and the FSM state encodings, from the shared defines file.
REQ-031 SHALL place storage in one sub-module, data_ram_array, with one synchronous read port and one byte-enabled synchronous write port.
REQ-032 SHALL keep the FSM, counter and range check in data_ram.

Verification
REQ-033 SHALL cover: with WAIT_CYCLES = 1, store 0xDEADBEEF to 0x00000010 with sel 1111, then load 0x00000010 -> ack 2 cycles after each accept, data_o = 0xDEADBEEF.
REQ-034 SHALL cover: word 0x00000020 holds 0x11223344, store 0xAABBCCDD with sel 0100, then load -> data_o = 0x11BB3344.
REQ-035 SHALL cover: with DEPTH_LOG2 = 10, load from 0x00001000 -> ack with err_o = 1 and data_o = 0; storage unchanged when checked afterwards.
REQ-036 SHALL cover: with WAIT_CYCLES = 0, ce_i held at 1 across four loads -> ack every 2nd cycle, never two consecutive acks.
REQ-037 SHALL cover: store 0x12345678 accepted, rst pulsed low during WAIT, then load of the same word -> no ack before reset, old contents returned.
REQ-038 SHALL cover: ce_i dropped one cycle after accept -> transaction still acks at the nominal cycle.
